// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Signal bundle for mem_port_arbiter. It carries the IF
//               requester channel, the data (load/store) requester channel,
//               the pipeline flush and the shared SRAM-like port.
//               slave  : the arbiter's view of the bundle.
//               master : the surrounding environment's view, which drives the
//                        requests and the port responses.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
    // Pipeline control
    logic        flush;
    // Instruction-fetch channel
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    // Data load/store channel
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    // Shared memory port
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport slave (
        input  flush,
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
    );

    modport master (
        output flush,
        output inst_req, inst_addr,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one SRAM-like memory port between instruction fetch
//               and the data load/store path. One transaction is in flight at
//               a time: the request phase is registered, the response phase
//               passes straight through to the owning requester. Data wins
//               ties; after STARVE_LIMIT consecutive data grants made while IF
//               was waiting, IF is forced to win. A flush while a fetch is in
//               flight makes its response beat be consumed silently.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               port_io       - mem_port_arbiter_if.slave bundle
//                               (flush, IF channel, data channel, bus port)
// Parameters  : STARVE_LIMIT  - data grants tolerated while IF waits (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_port_arbiter_if.slave  port_io
);

    localparam int               CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t             state_q;
    logic               owner_q;      // 0 = IF, 1 = data
    logic               drop_q;       // in-flight fetch response must be discarded
    logic [CNT_W-1:0]   starve_q;
    logic               bus_req_q;
    logic               bus_wr_q;
    logic [3:0]         bus_wstrb_q;
    logic [31:0]        bus_addr_q;
    logic [31:0]        bus_wdata_q;

    logic               w_grant_inst;
    logic               w_grant_data;
    logic               w_resp;
    logic               w_inst_resp;
    logic               w_data_resp;
    logic               w_flush_inst;

    // Grant decision. Gated by rst so no addr_ok can leak out while the
    // block is being reset.
    always_comb begin
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
        if (!rst && (state_q == S_IDLE)) begin
            if ((starve_q == CNT_MAX) && port_io.inst_req) begin
                w_grant_inst = 1'b1;
            end else if (port_io.data_req) begin
                w_grant_data = 1'b1;
            end else if (port_io.inst_req) begin
                w_grant_inst = 1'b1;
            end
        end
    end

    // A flush arriving together with the response beat still drops it, so
    // the live flush is folded in alongside the registered drop flag.
    assign w_flush_inst = port_io.flush && !owner_q;
    assign w_resp       = !rst && (state_q == S_DATA) && port_io.bus_data_ok;
    assign w_data_resp  = w_resp && owner_q;
    assign w_inst_resp  = w_resp && !owner_q && !drop_q && !port_io.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            drop_q      <= 1'b0;
            starve_q    <= '0;
            bus_req_q   <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_wstrb_q <= 4'd0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_grant_inst) begin
                        state_q     <= S_ADDR;
                        owner_q     <= 1'b0;
                        drop_q      <= port_io.flush;
                        starve_q    <= '0;
                        bus_req_q   <= 1'b1;
                        bus_wr_q    <= 1'b0;
                        bus_wstrb_q <= 4'd0;
                        bus_addr_q  <= port_io.inst_addr;
                        bus_wdata_q <= 32'd0;
                    end else if (w_grant_data) begin
                        state_q     <= S_ADDR;
                        owner_q     <= 1'b1;
                        drop_q      <= 1'b0;
                        // Only data grants that made a waiting IF wait longer count.
                        if (port_io.inst_req && (starve_q != CNT_MAX)) begin
                            starve_q <= starve_q + CNT_W'(1);
                        end
                        bus_req_q   <= 1'b1;
                        bus_wr_q    <= port_io.data_wr;
                        bus_wstrb_q <= port_io.data_wr ? port_io.data_wstrb : 4'd0;
                        bus_addr_q  <= port_io.data_addr;
                        bus_wdata_q <= port_io.data_wdata;
                    end
                end
                S_ADDR: begin
                    if (w_flush_inst) begin
                        drop_q <= 1'b1;
                    end
                    if (port_io.bus_addr_ok) begin
                        state_q   <= S_DATA;
                        bus_req_q <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (w_flush_inst) begin
                        drop_q <= 1'b1;
                    end
                    if (port_io.bus_data_ok) begin
                        state_q <= S_IDLE;
                        drop_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    drop_q    <= 1'b0;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign port_io.inst_addr_ok = w_grant_inst;
    assign port_io.data_addr_ok = w_grant_data;
    assign port_io.inst_data_ok = w_inst_resp;
    assign port_io.inst_rdata   = w_inst_resp ? port_io.bus_rdata : 32'd0;
    assign port_io.data_data_ok = w_data_resp;
    assign port_io.data_rdata   = w_data_resp ? port_io.bus_rdata : 32'd0;
    assign port_io.bus_req      = bus_req_q;
    assign port_io.bus_wr       = bus_wr_q;
    assign port_io.bus_wstrb    = bus_wstrb_q;
    assign port_io.bus_addr     = bus_addr_q;
    assign port_io.bus_wdata    = bus_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Directed scenarios
//               followed by a randomized run checked against a transaction-
//               level model (grant rule, starvation count, drop flag, memory).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] mem [16];

    mem_port_arbiter_if pif ();

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .port_io (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        pif.flush       = 1'b0;
        pif.inst_req    = 1'b0;
        pif.inst_addr   = 32'd0;
        pif.data_req    = 1'b0;
        pif.data_wr     = 1'b0;
        pif.data_wstrb  = 4'd0;
        pif.data_addr   = 32'd0;
        pif.data_wdata  = 32'd0;
        pif.bus_addr_ok = 1'b0;
        pif.bus_data_ok = 1'b0;
        pif.bus_rdata   = 32'd0;
    endtask

    function automatic logic [137:0] all_outs();
        return {pif.bus_req, pif.bus_wr, pif.bus_wstrb, pif.bus_addr, pif.bus_wdata,
                pif.inst_addr_ok, pif.inst_data_ok, pif.inst_rdata,
                pif.data_addr_ok, pif.data_data_ok, pif.data_rdata};
    endfunction

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        pif.inst_req = 1'b1;
        pif.data_req = 1'b1;
        cyc();
        smp();
        total++; if (all_outs() !== 138'd0) begin bad++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
        cyc();
        rst = 1'b0;
        clear_inputs();
        cyc();
        smp();
        total++; if ({pif.bus_req, pif.inst_addr_ok, pif.data_addr_ok} !== 3'b000) begin bad++; $display("FAIL reset_idle: got %b want 000", {pif.bus_req, pif.inst_addr_ok, pif.data_addr_ok}); end
    endtask

    task automatic test_single_fetch();
        cyc();
        pif.inst_req = 1'b1; pif.inst_addr = 32'hBFC0_0000;
        smp();
        total++; if ({pif.inst_addr_ok, pif.data_addr_ok} !== 2'b10) begin bad++; $display("FAIL fetch_addr_ok: got %b want 10", {pif.inst_addr_ok, pif.data_addr_ok}); end
        cyc();
        pif.inst_req = 1'b0; pif.bus_addr_ok = 1'b1;
        smp();
        total++; if ({pif.bus_req, pif.bus_wr, pif.bus_wstrb, pif.bus_addr} !== {1'b1, 1'b0, 4'd0, 32'hBFC0_0000}) begin bad++; $display("FAIL fetch_bus: got req=%b wr=%b strb=%h addr=%h want 1 0 0 bfc00000", pif.bus_req, pif.bus_wr, pif.bus_wstrb, pif.bus_addr); end
        total++; if (pif.inst_addr_ok !== 1'b0) begin bad++; $display("FAIL fetch_busy_addr_ok: got %b want 0", pif.inst_addr_ok); end
        cyc();
        pif.bus_addr_ok = 1'b0; pif.bus_data_ok = 1'b1; pif.bus_rdata = 32'h3C1D_BFC0;
        smp();
        total++; if ({pif.inst_data_ok, pif.inst_rdata, pif.data_data_ok} !== {1'b1, 32'h3C1D_BFC0, 1'b0}) begin bad++; $display("FAIL fetch_data: got ok=%b rdata=%h dok=%b want 1 3c1dbfc0 0", pif.inst_data_ok, pif.inst_rdata, pif.data_data_ok); end
        total++; if (pif.bus_req !== 1'b0) begin bad++; $display("FAIL fetch_bus_req_drop: got %b want 0", pif.bus_req); end
        cyc();
        pif.bus_data_ok = 1'b0;
        smp();
        total++; if ({pif.inst_data_ok, pif.bus_req} !== 2'b00) begin bad++; $display("FAIL fetch_after: got %b want 00", {pif.inst_data_ok, pif.bus_req}); end
    endtask

    task automatic test_contention();
        cyc();
        pif.inst_req = 1'b1; pif.inst_addr = 32'hBFC0_0004;
        pif.data_req = 1'b1; pif.data_wr = 1'b1; pif.data_addr = 32'h8000_1000;
        pif.data_wstrb = 4'b0011; pif.data_wdata = 32'h1234_5678;
        smp();
        total++; if ({pif.data_addr_ok, pif.inst_addr_ok} !== 2'b10) begin bad++; $display("FAIL cont_grant: got d=%b i=%b want 1 0", pif.data_addr_ok, pif.inst_addr_ok); end
        cyc();
        pif.data_req = 1'b0; pif.bus_addr_ok = 1'b1;
        smp();
        total++; if ({pif.bus_wr, pif.bus_wstrb, pif.bus_addr, pif.bus_wdata} !== {1'b1, 4'b0011, 32'h8000_1000, 32'h1234_5678}) begin bad++; $display("FAIL cont_bus: got wr=%b strb=%b addr=%h wdata=%h want 1 0011 80001000 12345678", pif.bus_wr, pif.bus_wstrb, pif.bus_addr, pif.bus_wdata); end
        cyc();
        pif.bus_addr_ok = 1'b0; pif.bus_data_ok = 1'b1; pif.bus_rdata = 32'h0;
        smp();
        total++; if ({pif.data_data_ok, pif.inst_data_ok, pif.inst_addr_ok} !== 3'b100) begin bad++; $display("FAIL cont_data_ok: got %b want 100", {pif.data_data_ok, pif.inst_data_ok, pif.inst_addr_ok}); end
        cyc();
        pif.bus_data_ok = 1'b0;
        smp();
        total++; if (pif.inst_addr_ok !== 1'b1) begin bad++; $display("FAIL cont_if_next: got %b want 1", pif.inst_addr_ok); end
        cyc();
        pif.inst_req = 1'b0; pif.bus_addr_ok = 1'b1;
        smp();
        total++; if (pif.bus_addr !== 32'hBFC0_0004) begin bad++; $display("FAIL cont_if_addr: got %h want bfc00004", pif.bus_addr); end
        cyc();
        pif.bus_addr_ok = 1'b0; pif.bus_data_ok = 1'b1; pif.bus_rdata = 32'h2400_0001;
        smp();
        total++; if ({pif.inst_data_ok, pif.inst_rdata} !== {1'b1, 32'h2400_0001}) begin bad++; $display("FAIL cont_if_data: got %b %h want 1 24000001", pif.inst_data_ok, pif.inst_rdata); end
        cyc();
        clear_inputs();
    endtask

    task automatic test_starvation();
        string got;
        string want;
        got = ""; want = "";
        pif.inst_req = 1'b1; pif.inst_addr = 32'hBFC0_0100;
        pif.data_req = 1'b1; pif.data_wr = 1'b0; pif.data_addr = 32'h8000_0200;
        for (int g = 0; g < 10; g++) begin
            smp();
            want = {want, (g % 5 == 4) ? "I" : "D"};
            if (pif.inst_addr_ok && !pif.data_addr_ok)      got = {got, "I"};
            else if (pif.data_addr_ok && !pif.inst_addr_ok) got = {got, "D"};
            else                                            got = {got, "x"};
            cyc();
            pif.bus_addr_ok = 1'b1;
            cyc();
            pif.bus_addr_ok = 1'b0; pif.bus_data_ok = 1'b1;
            cyc();
            pif.bus_data_ok = 1'b0;
            if (g == 9) begin
                pif.inst_req = 1'b0; pif.data_req = 1'b0;
            end
        end
        total++; if (got != want) begin bad++; $display("FAIL starve_seq: got %s want %s", got, want); end
    endtask

    task automatic test_flush_drop();
        pif.inst_req = 1'b1; pif.inst_addr = 32'hBFC0_0010;
        smp();
        total++; if (pif.inst_addr_ok !== 1'b1) begin bad++; $display("FAIL flush_grant: got %b want 1", pif.inst_addr_ok); end
        cyc();
        pif.inst_req = 1'b0; pif.bus_addr_ok = 1'b1;
        cyc();
        pif.bus_addr_ok = 1'b0; pif.flush = 1'b1;
        smp();
        total++; if (pif.inst_data_ok !== 1'b0) begin bad++; $display("FAIL flush_early_ok: got %b want 0", pif.inst_data_ok); end
        cyc();
        pif.flush = 1'b0; pif.bus_data_ok = 1'b1; pif.bus_rdata = 32'hDEAD_BEEF;
        smp();
        total++; if ({pif.inst_data_ok, pif.data_data_ok} !== 2'b00) begin bad++; $display("FAIL flush_drop: got %b want 00", {pif.inst_data_ok, pif.data_data_ok}); end
        cyc();
        pif.bus_data_ok = 1'b0; pif.inst_req = 1'b1; pif.inst_addr = 32'hBFC0_0014;
        smp();
        total++; if (pif.inst_addr_ok !== 1'b1) begin bad++; $display("FAIL flush_back_idle: got %b want 1", pif.inst_addr_ok); end
        cyc();
        pif.inst_req = 1'b0; pif.bus_addr_ok = 1'b1;
        cyc();
        pif.bus_addr_ok = 1'b0; pif.bus_data_ok = 1'b1; pif.bus_rdata = 32'h0000_1111;
        smp();
        total++; if ({pif.inst_data_ok, pif.inst_rdata} !== {1'b1, 32'h0000_1111}) begin bad++; $display("FAIL flush_next_fetch: got %b %h want 1 00001111", pif.inst_data_ok, pif.inst_rdata); end
        cyc();
        pif.bus_data_ok = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [68:0] want;
        want = {1'b1, 4'hF, 32'h8000_2000, 32'hCAFE_F00D};
        pif.data_req = 1'b1; pif.data_wr = 1'b1; pif.data_wstrb = 4'hF;
        pif.data_addr = 32'h8000_2000; pif.data_wdata = 32'hCAFE_F00D;
        smp();
        total++; if (pif.data_addr_ok !== 1'b1) begin bad++; $display("FAIL bp_grant: got %b want 1", pif.data_addr_ok); end
        cyc();
        // Requesters keep asking with different fields; nothing may move.
        pif.data_addr = 32'h8000_3000; pif.data_wdata = 32'h0; pif.data_wstrb = 4'h1;
        pif.inst_req = 1'b1; pif.inst_addr = 32'hBFC0_0040;
        for (int k = 0; k < 5; k++) begin
            smp();
            total++; if ({pif.bus_req, pif.bus_wr, pif.bus_wstrb, pif.bus_addr, pif.bus_wdata} !== {1'b1, want}) begin bad++; $display("FAIL bp_hold%0d: got req=%b %h want 1 %h", k, pif.bus_req, {pif.bus_wr, pif.bus_wstrb, pif.bus_addr, pif.bus_wdata}, want); end
            total++; if ({pif.inst_addr_ok, pif.data_addr_ok} !== 2'b00) begin bad++; $display("FAIL bp_addr_ok%0d: got %b want 00", k, {pif.inst_addr_ok, pif.data_addr_ok}); end
            cyc();
        end
        pif.inst_req = 1'b0; pif.data_req = 1'b0; pif.bus_addr_ok = 1'b1;
        cyc();
        pif.bus_addr_ok = 1'b0; pif.bus_data_ok = 1'b1;
        smp();
        total++; if (pif.data_data_ok !== 1'b1) begin bad++; $display("FAIL bp_done: got %b want 1", pif.data_data_ok); end
        cyc();
        clear_inputs();
    endtask

    task automatic test_reset_midop();
        int stray;
        pif.inst_req = 1'b1; pif.inst_addr = 32'hBFC0_0080;
        cyc();
        pif.inst_req = 1'b0; pif.bus_addr_ok = 1'b1;
        cyc();
        pif.bus_addr_ok = 1'b0; rst = 1'b1;
        cyc();
        smp();
        total++; if (all_outs() !== 138'd0) begin bad++; $display("FAIL midop_reset: got %h want 0", all_outs()); end
        cyc();
        rst = 1'b0; pif.bus_data_ok = 1'b1; pif.bus_rdata = 32'h5555_AAAA;
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            smp();
            if (pif.inst_data_ok || pif.data_data_ok || pif.bus_req) stray++;
            cyc();
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL midop_stray: got %0d want 0", stray); end
        clear_inputs();
    endtask

    task automatic test_random();
        int          ph;         // 0 idle, 1 request phase, 2 response phase
        int          starve;
        bit          ip, dp;
        bit          t_own, t_wr, t_drop;
        logic [3:0]  t_wstrb;
        logic [31:0] t_addr, t_wdata;
        bit          e_ia, e_da, e_id, e_dd, resp, drop_now;
        logic [31:0] wmask;

        for (int i = 0; i < 16; i++) mem[i] = 32'h5A00_0000 + 32'(i) * 32'h0101_0101;
        clear_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        ph = 0; starve = 0; ip = 0; dp = 0;
        t_own = 0; t_wr = 0; t_drop = 0; t_wstrb = 0; t_addr = 0; t_wdata = 0;

        for (int c = 0; c < 3000; c++) begin
            if (!ip && ($urandom_range(0, 2) == 0)) begin
                ip = 1;
                pif.inst_addr = {16'h8000, 10'd0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (!dp && ($urandom_range(0, 2) == 0)) begin
                dp = 1;
                pif.data_wr    = ($urandom_range(0, 1) == 1);
                pif.data_wstrb = 4'($urandom_range(0, 15));
                pif.data_wdata = $urandom;
                pif.data_addr  = {16'h8000, 10'd0, 4'($urandom_range(0, 15)), 2'b00};
            end
            pif.inst_req    = ip;
            pif.data_req    = dp;
            pif.flush       = ($urandom_range(0, 7) == 0);
            pif.bus_addr_ok = (ph == 1) && ($urandom_range(0, 1) == 1);
            pif.bus_data_ok = (ph == 2) && ($urandom_range(0, 1) == 1);
            if (pif.bus_data_ok && !t_wr) pif.bus_rdata = mem[t_addr[5:2]];
            else                          pif.bus_rdata = $urandom;

            smp();
            e_ia = 0; e_da = 0;
            if (ph == 0) begin
                if (starve == 4 && ip) e_ia = 1;
                else if (dp)           e_da = 1;
                else if (ip)           e_ia = 1;
            end
            total++; if ({pif.inst_addr_ok, pif.data_addr_ok} !== {e_ia, e_da}) begin bad++; $display("FAIL rnd_grant c=%0d: got i=%b d=%b want i=%b d=%b", c, pif.inst_addr_ok, pif.data_addr_ok, e_ia, e_da); end

            wmask = t_own ? 32'hFFFF_FFFF : 32'h0;
            total++;
            if (ph == 1) begin
                if ({pif.bus_req, pif.bus_wr, pif.bus_wstrb, pif.bus_addr, pif.bus_wdata & wmask} !== {1'b1, t_wr, t_wstrb, t_addr, t_wdata & wmask}) begin
                    bad++; $display("FAIL rnd_bus c=%0d: got req=%b wr=%b strb=%h addr=%h wdata=%h want 1 %b %h %h %h", c, pif.bus_req, pif.bus_wr, pif.bus_wstrb, pif.bus_addr, pif.bus_wdata & wmask, t_wr, t_wstrb, t_addr, t_wdata & wmask);
                end
            end else if (pif.bus_req !== 1'b0) begin
                bad++; $display("FAIL rnd_bus_idle c=%0d: got req=%b want 0", c, pif.bus_req);
            end

            resp     = (ph == 2) && pif.bus_data_ok;
            drop_now = t_drop || (pif.flush && !t_own);
            e_id     = resp && !t_own && !drop_now;
            e_dd     = resp && t_own;
            total++; if ({pif.inst_data_ok, pif.data_data_ok} !== {e_id, e_dd}) begin bad++; $display("FAIL rnd_data_ok c=%0d: got i=%b d=%b want i=%b d=%b", c, pif.inst_data_ok, pif.data_data_ok, e_id, e_dd); end
            if (e_id) begin
                total++; if (pif.inst_rdata !== pif.bus_rdata) begin bad++; $display("FAIL rnd_inst_rdata c=%0d: got %h want %h", c, pif.inst_rdata, pif.bus_rdata); end
            end
            if (e_dd) begin
                total++; if (pif.data_rdata !== pif.bus_rdata) begin bad++; $display("FAIL rnd_data_rdata c=%0d: got %h want %h", c, pif.data_rdata, pif.bus_rdata); end
            end

            if (e_ia) begin
                starve = 0; t_own = 0; t_addr = pif.inst_addr; t_wr = 0; t_wstrb = 0;
                t_wdata = 0; t_drop = pif.flush; ip = 0; ph = 1;
            end else if (e_da) begin
                if (ip && starve < 4) starve++;
                t_own = 1; t_addr = pif.data_addr; t_wr = pif.data_wr;
                t_wstrb = pif.data_wr ? pif.data_wstrb : 4'd0;
                t_wdata = pif.data_wdata; t_drop = 0; dp = 0; ph = 1;
            end else if (ph == 1) begin
                if (pif.flush && !t_own) t_drop = 1;
                if (pif.bus_addr_ok) ph = 2;
            end else if (ph == 2) begin
                if (pif.flush && !t_own) t_drop = 1;
                if (pif.bus_data_ok) begin
                    if (t_wr) begin
                        for (int b = 0; b < 4; b++)
                            if (t_wstrb[b]) mem[t_addr[5:2]][8*b +: 8] = t_wdata[8*b +: 8];
                    end
                    ph = 0;
                end
            end
            cyc();
        end
        clear_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_flush_drop();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external SRAM-like memory port between the instruction-fetch requester (IF) and the data-access requester (EX/MEM load/store path). It runs one transaction at a time with a registered request phase and a pass-through response phase. Data accesses win ties, and a bounded starvation counter protects instruction fetch. Instruction responses are discarded when a pipeline flush arrives while the fetch is outstanding.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while IF is waiting before IF is forced to win the next grant.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush. Marks any outstanding or just-captured instruction transaction as dropped.
- inst_req  in  1  IF read request.
- inst_addr  in  32  IF byte address.
- inst_addr_ok  out  1  IF request captured this cycle.
- inst_data_ok  out  1  IF read data valid this cycle.
- inst_rdata  out  32  IF read data.
- data_req  in  1  data request.
- data_wr  in  1  1 = write, 0 = read.
- data_wstrb  in  4  byte enables, used only for writes.
- data_addr  in  32  data byte address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data request captured this cycle.
- data_data_ok  out  1  data read data valid, or write completed, this cycle.
- data_rdata  out  32  data read data.
- bus_req  out  1  shared-port request.
- bus_wr  out  1  shared-port write.
- bus_wstrb  out  4  shared-port byte enables.
- bus_addr  out  32  shared-port address.
- bus_wdata  out  32  shared-port write data.
- bus_addr_ok  in  1  port accepted the request.
- bus_data_ok  in  1  port response valid.
- bus_rdata  in  32  port read data.

## Operation
- FSM states:
  - IDLE
  - ADDR: bus_req is held high.
  - DATA: waiting for bus_data_ok.
- **IDLE grant.** Evaluated only in IDLE.
  - If the starvation counter equals STARVE_LIMIT and inst_req=1, grant IF.
  - Otherwise, if data_req=1, grant data.
  - Otherwise, if inst_req=1, grant IF.
- **On grant:**
  - Pulse the winner's addr_ok for that cycle.
  - Latch addr, wr, wstrb and wdata into the bus registers. For IF, wr=0 and wstrb=0. For a data read, wstrb is forced to 0.
  - Latch owner (0 = IF, 1 = data) and go to ADDR.
- **ADDR.** bus_req=1 with the latched fields. When bus_addr_ok=1, go to DATA. bus_req drops in that same cycle's next state.
- **DATA.** When bus_data_ok=1, return to IDLE and route the response to the owner.
  - Owner data: data_data_ok=1 and data_rdata=bus_rdata, combinational in that cycle.
  - Owner IF and not dropped: inst_data_ok=1 and inst_rdata=bus_rdata.
  - Owner IF and dropped: both data_ok outputs stay 0; the beat is consumed silently.
- **Drop flag.**
  - Set when flush=1 while owner=IF in ADDR or DATA.
  - Also set when flush=1 in the IDLE cycle an IF grant occurs.
  - Cleared on return to IDLE.
  - Data transactions are never dropped: EX already masks squashed stores before requesting.
- **Starvation counter** (width clog2(STARVE_LIMIT+1)):
  - Increments on each data grant made while inst_req=1.
  - Resets to 0 on any IF grant.
  - Saturates at STARVE_LIMIT.
- Both addr_ok outputs are 0 outside IDLE, so no new request is accepted until the current one completes.
- **Reset values.** State=IDLE, drop=0, counter=0, owner=0. Every output is 0, including bus_addr, bus_wdata, bus_wstrb and both rdata outputs.
- **Reset mid-transaction.** Abandons the transaction. The port is assumed reset together with this block, and no data_ok is issued afterwards.

## Timing
- Cycle 0: request sampled in IDLE, addr_ok=1.
- Cycle 1: earliest bus_req=1.
- Cycle 1 (earliest): bus_addr_ok, so DATA from cycle 2.
- Cycle 2 (earliest): bus_data_ok gives requester data_ok in the same cycle.
- Cycle 3: IDLE, next grant possible. Minimum occupancy is 3 cycles per transaction.
- bus_* request fields are stable from the first ADDR cycle until bus_addr_ok.
- Simultaneous inst_req and data_req in IDLE: data wins, unless the starvation limit has been reached.
- flush and bus_data_ok in the same DATA cycle with owner IF: the response is dropped.

## Test plan
- **Single fetch.** Reset, then inst_req=1 with addr 0xBFC00000 at cycle 0 and zero-wait port. Expect:
  - inst_addr_ok at cycle 0.
  - bus_req at cycle 1 with addr 0xBFC00000, wr=0, wstrb=0.
  - bus_rdata 0x3C1DBFC0 at cycle 2 giving inst_data_ok=1, inst_rdata=0x3C1DBFC0.
- **Contention.** inst_req and data_req (write, addr 0x80001000, wstrb 4'b0011, wdata 0x12345678) both high in IDLE. Expect:
  - data_addr_ok=1 and inst_addr_ok=0.
  - bus_wstrb=4'b0011.
  - IF granted in the IDLE cycle after data_data_ok.
- **Starvation.** STARVE_LIMIT=4, both requests held high continuously. Expect the grant sequence D, D, D, D, I, D, D, D, D, I.
- **Flush drop.** IF granted; flush=1 pulsed during DATA; port returns 0xDEADBEEF. Expect inst_data_ok to stay 0 and the FSM to return to IDLE. The next fetch then returns data normally.
- **Backpressure.** bus_addr_ok held 0 for 5 cycles. Expect bus_req and every bus_* field held constant throughout, with no addr_ok to either requester.
- **Reset mid-op.** rst=1 during DATA. Expect all outputs 0 the next cycle, and no data_ok after rst deasserts.
